// File: rtl/clk_ce_pkg.sv
// clk_ce_pkg: shared types, constants and helpers for the clock-enable bank
package clk_ce_pkg;

    parameter int CE_ACC_W = 32;
    localparam int DEFAULT_LOCK_CYC = 16;

    typedef logic [CE_ACC_W-1:0] acc_t;
    typedef logic [3:0] ch_idx_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        QUALIFY,
        LOCKED
    } lock_state_e;

    // Channel index width, never narrower than one bit
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_ce_nco.sv
// clk_ce_nco: one phase-accumulator enable channel with shadowed increment (optional clk_div via CE_BANK_TOGGLE_OUT_EN)
module clk_ce_nco
    import clk_ce_pkg::*;
#(
    parameter int               ACC_W       = CE_ACC_W,
    parameter logic [ACC_W-1:0] DEFAULT_INC = {2'b01, {(ACC_W-2){1'b0}}}
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             pending,
    output logic             ce
`ifdef CE_BANK_TOGGLE_OUT_EN
    ,
    output logic             clk_div
`endif
);

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_d, acc_q, inc_d, inc_q, shadow_d, shadow_q;
    logic             ce_d, ce_q, pend_d, pend_q, apply;
`ifdef CE_BANK_TOGGLE_OUT_EN
    logic             clk_div_d, clk_div_q;
`endif

    // Accumulate while locked; swap in the shadow increment only on a carry so no interval is cut short
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d    = en ? sum[ACC_W-1:0] : '0;
        ce_d     = en & sum[ACC_W];
        apply    = pend_q & (~en | ~|inc_q | sum[ACC_W]);
        inc_d    = apply ? shadow_q : inc_q;
        shadow_d = wr ? wr_inc : shadow_q;
        pend_d   = wr | (pend_q & ~apply);
`ifdef CE_BANK_TOGGLE_OUT_EN
        clk_div_d = clk_div_q ^ ce_d;
`endif
    end

    // Channel state registers
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            inc_q    <= DEFAULT_INC;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            ce_q     <= 1'b0;
`ifdef CE_BANK_TOGGLE_OUT_EN
            clk_div_q <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            ce_q     <= ce_d;
`ifdef CE_BANK_TOGGLE_OUT_EN
            clk_div_q <= clk_div_d;
`endif
        end
    end

    assign pending = pend_q;
    assign ce      = ce_q;
`ifdef CE_BANK_TOGGLE_OUT_EN
    assign clk_div = clk_div_q;
`endif

endmodule

// File: rtl/clk_ce_bank.sv
// clk_ce_bank: NUM_CH NCO clock-enable streams gated by a qualified PLL lock (optional clk_div via CE_BANK_TOGGLE_OUT_EN)
module clk_ce_bank
    import clk_ce_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               ACC_W       = CE_ACC_W,
    parameter int               LOCK_CYC    = DEFAULT_LOCK_CYC,
    parameter logic [ACC_W-1:0] DEFAULT_INC = {2'b01, {(ACC_W-2){1'b0}}},
    localparam int              CHW         = ch_idx_w(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] ce,
    output logic              ce_locked
`ifdef CE_BANK_TOGGLE_OUT_EN
    ,
    output logic [NUM_CH-1:0] clk_div
`endif
);

    localparam int CW = $clog2(LOCK_CYC + 1);

    lock_state_e       state_d, state_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic [1:0]        sync_d, sync_q;
    logic              locked_d, locked_q;
    logic [NUM_CH-1:0] pending;
    logic [2**CHW-1:0] pend_ext;

    // Lock qualification: any synchronised low restarts; LOCK_CYC consecutive highs reach LOCKED
    always_comb begin
        sync_d   = {sync_q[0], pll_locked};
        cnt_d    = sync_q[1] ? ((state_q == LOCKED) ? cnt_q : cnt_q + 1'b1) : '0;
        state_d  = !sync_q[1] ? WAIT_SYNC : (cnt_d == CW'(LOCK_CYC)) ? LOCKED : QUALIFY;
        locked_d = state_d == LOCKED;
    end

    // Synchroniser and lock FSM with registered ce_locked
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            state_q  <= WAIT_SYNC;
            locked_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            locked_q <= locked_d;
        end
    end

    // Unused index slots read as not pending, so out-of-range channels accept and drop writes
    always_comb begin
        pend_ext             = '0;
        pend_ext[NUM_CH-1:0] = pending;
    end

    assign cfg_ready = !pend_ext[cfg_ch];
    assign ce_locked = locked_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_ce_nco #(
            .ACC_W       (ACC_W),
            .DEFAULT_INC (DEFAULT_INC)
        ) u_nco (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .en      (locked_q),
            .wr      (cfg_valid && cfg_ready && (cfg_ch == CHW'(i))),
            .wr_inc  (cfg_inc),
            .pending (pending[i]),
            .ce      (ce[i])
`ifdef CE_BANK_TOGGLE_OUT_EN
            ,
            .clk_div (clk_div[i])
`endif
        );
    end

endmodule

// File: tb/tb_clk_ce_bank.sv
// tb_clk_ce_bank: directed self-checking bench for clk_ce_bank (ACC_W=8, three channels)
module tb_clk_ce_bank;

    localparam int NUM_CH   = 3;
    localparam int ACC_W    = 8;
    localparam int LOCK_CYC = 16;
    localparam int CHW      = 2;

    logic              refclk = 1'b0;
    logic              rst_n, pll_locked, cfg_valid, cfg_ready, ce_locked;
    logic [CHW-1:0]    cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] ce, exp_ce;
`ifdef CE_BANK_TOGGLE_OUT_EN
    logic [NUM_CH-1:0] clk_div;
`endif
    int errors = 0;
    int checks = 0;

    always #5 refclk = ~refclk;

    clk_ce_bank #(
        .NUM_CH   (NUM_CH),
        .ACC_W    (ACC_W),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .ce         (ce),
        .ce_locked  (ce_locked)
`ifdef CE_BANK_TOGGLE_OUT_EN
        ,
        .clk_div    (clk_div)
`endif
    );

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pll_locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
        repeat (3) tick;
        checks++; if (ce !== 3'b000) begin errors++; $display("FAIL reset_ce: got %b expected 000", ce); end
        checks++; if (ce_locked !== 1'b0) begin errors++; $display("FAIL reset_ce_locked: got %b expected 0", ce_locked); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        #3 rst_n = 1'b1;
        repeat (3) tick;
        checks++; if (ce_locked !== 1'b0) begin errors++; $display("FAIL unlocked_idle: got %b expected 0", ce_locked); end
    endtask

    task automatic test_lock;
        int n = 0;
        pll_locked = 1'b1;
        do begin tick; n++; end while (ce_locked !== 1'b1 && n < 40);
        checks++; if (n != 18) begin errors++; $display("FAIL lock_latency: got %0d cycles expected 18", n); end
        for (int c = 1; c <= 8; c++) begin
            tick;
            exp_ce = (c % 4 == 0) ? 3'b111 : 3'b000;
            checks++; if (ce !== exp_ce) begin errors++; $display("FAIL default_rate c%0d: got %b expected %b", c, ce, exp_ce); end
        end
    endtask

    task automatic test_rate_update;
        logic e1;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd96;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL upd_ready_before: got %b expected 1", cfg_ready); end
        tick;
        cfg_valid = 1'b0;
        for (int c = 9; c <= 28; c++) begin
            e1 = (c == 12) || (c > 12 && ((c - 12) % 8 == 3 || (c - 12) % 8 == 6 || (c - 12) % 8 == 0));
            checks++; if (ce[1] !== e1) begin errors++; $display("FAIL ch1_rate c%0d: got %b expected %b", c, ce[1], e1); end
            checks++; if (ce[0] !== (c % 4 == 0)) begin errors++; $display("FAIL ch0_rate c%0d: got %b expected %b", c, ce[0], c % 4 == 0); end
            checks++; if (cfg_ready !== (c >= 12)) begin errors++; $display("FAIL ch1_ready c%0d: got %b expected %b", c, cfg_ready, c >= 12); end
            if (c < 28) tick;
        end
    endtask

    task automatic test_stop_restart;
        logic ok_xfer, e2, er;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 8'd0;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready_before: got %b expected 1", cfg_ready); end
        tick;
        cfg_inc = 8'd128;
        for (int c = 29; c <= 42; c++) begin
            #1;
            e2 = (c == 32) || (c >= 36 && c % 2 == 0);
            er = (c == 32) || (c >= 34);
            checks++; if (ce[2] !== e2) begin errors++; $display("FAIL ch2_stop c%0d: got %b expected %b", c, ce[2], e2); end
            checks++; if (cfg_ready !== er) begin errors++; $display("FAIL ch2_ready c%0d: got %b expected %b", c, cfg_ready, er); end
            checks++; if (ce[0] !== (c % 4 == 0)) begin errors++; $display("FAIL ch0_steady c%0d: got %b expected %b", c, ce[0], c % 4 == 0); end
            ok_xfer = cfg_valid && cfg_ready;
            if (c < 42) begin
                tick;
                if (ok_xfer) cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_lock_drop;
        logic [NUM_CH-1:0] tbl [1:4];
        int n = 1;
        tbl[1] = 3'b000; tbl[2] = 3'b100; tbl[3] = 3'b010; tbl[4] = 3'b101;
        pll_locked = 1'b0;
        tick;
        pll_locked = 1'b1;
        checks++; if (ce_locked !== 1'b1) begin errors++; $display("FAIL drop_edge1: got %b expected 1", ce_locked); end
        tick; n = 1;
        checks++; if (ce_locked !== 1'b1) begin errors++; $display("FAIL drop_edge2: got %b expected 1", ce_locked); end
        tick; n = 2;
        checks++; if ({ce_locked, ce} !== 4'b0000) begin errors++; $display("FAIL drop_edge3: got %b expected 0000", {ce_locked, ce}); end
        while (ce_locked !== 1'b1 && n < 40) begin
            tick; n++;
            if (n < 18) begin
                checks++; if ({ce_locked, ce} !== 4'b0000) begin errors++; $display("FAIL gated_n%0d: got %b expected 0000", n, {ce_locked, ce}); end
            end
        end
        checks++; if (n != 18) begin errors++; $display("FAIL requal_latency: got %0d cycles expected 18", n); end
        for (int c = 1; c <= 4; c++) begin
            tick;
            checks++; if (ce !== tbl[c]) begin errors++; $display("FAIL requal_phase c%0d: got %b expected %b", c, ce, tbl[c]); end
        end
    endtask

    task automatic test_async_reset;
        int n = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ce !== 3'b000) begin errors++; $display("FAIL async_ce: got %b expected 000", ce); end
        checks++; if (ce_locked !== 1'b0) begin errors++; $display("FAIL async_locked: got %b expected 0", ce_locked); end
        #2 rst_n = 1'b1;
        do begin tick; n++; end while (ce_locked !== 1'b1 && n < 40);
        checks++; if (n != 18) begin errors++; $display("FAIL reset_relock: got %0d cycles expected 18", n); end
    endtask

    task automatic test_out_of_range;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 8'd200;
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b expected 1", cfg_ready); end
        tick;
        cfg_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_ch = CHW'(k);
            #1;
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_no_pending ch%0d: got %b expected 1", k, cfg_ready); end
        end
        for (int c = 2; c <= 4; c++) begin
            tick;
            exp_ce = (c == 4) ? 3'b111 : 3'b000;
            checks++; if (ce !== exp_ce) begin errors++; $display("FAIL reset_inc c%0d: got %b expected %b", c, ce, exp_ce); end
        end
    endtask

`ifdef CE_BANK_TOGGLE_OUT_EN
    task automatic test_toggle;
        logic [NUM_CH-1:0] ed;
        for (int c = 4; c <= 12; c++) begin
            ed = ((c / 4) % 2 == 1) ? 3'b111 : 3'b000;
            checks++; if (clk_div !== ed) begin errors++; $display("FAIL clk_div c%0d: got %b expected %b", c, clk_div, ed); end
            if (c < 12) tick;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_lock;
        test_rate_update;
        test_stop_restart;
        test_lock_drop;
        test_async_reset;
        test_out_of_range;
`ifdef CE_BANK_TOGGLE_OUT_EN
        test_toggle;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
